// File: rtl/alu_pkg.sv
// Shared ALU definitions: RV32I opcodes, funct3 ALU op codes and the issue request record.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] src_a;
        logic [ALU_W-1:0] src_b;
        logic [2:0]       op;
        logic             alt;
        logic             illegal;
    } alu_req_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ALU operand/control bus from the issue register (master) to the EX-stage ALU (slave).
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_src_a;
    logic [XLEN-1:0] out_src_b;
    logic [2:0]      out_op;
    logic            out_alt;
    logic            out_illegal;

    modport master (
        output out_valid, out_src_a, out_src_b, out_op, out_alt, out_illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_src_a, out_src_b, out_op, out_alt, out_illegal,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP / OP-IMM / LUI / AUIPC decode into ALU operands and controls.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [ALU_W-1:0] rs1_data,
    input  logic [ALU_W-1:0] rs2_data,
    input  logic [ALU_W-1:0] imm,
    input  logic [ALU_W-1:0] pc,
    output alu_req_t         req
);

    // Only funct7[5] selects SUB/SRA; the remaining bits carry no meaning here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        req.src_a   = rs1_data;
        req.src_b   = imm;
        req.op      = ALU_ADD;
        req.alt     = 1'b0;
        req.illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                req.src_b = rs2_data;
                req.op    = funct3;
                req.alt   = funct7[5] & ((funct3 == ALU_ADD) | (funct3 == ALU_SR));
            end
            OPC_OP_IMM: begin
                req.op  = funct3;
                req.alt = funct7[5] & (funct3 == ALU_SR);
            end
            OPC_LUI: begin
                req.src_a = '0;
            end
            OPC_AUIPC: begin
                req.src_a = pc;
            end
            default: begin
                req.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register for the integer ALU; ALU_ISSUE_SKID_EN selects a two-entry
// skid buffer with registered in_ready, otherwise a single entry with pass-through ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    alu_issue_stage_if.master ex
);

    alu_req_t dec_req_p0;
    alu_req_t main_req_p1;
    logic     main_vld_p1;
    logic     in_fire;

    alu_issue_decode u_decode (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .imm      (in_imm),
        .pc       (in_pc),
        .req      (dec_req_p0)
    );

    assign in_fire = in_valid & in_ready;

    // ---- p0 -> p1: issue register ----
`ifdef ALU_ISSUE_SKID_EN
    alu_req_t skid_req_p1;
    logic     skid_vld_p1;

    assign in_ready = ~skid_vld_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_req_p1 <= '0;
            skid_req_p1 <= '0;
        end else if (flush) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!main_vld_p1 || ex.out_ready) begin
            // Main is free next cycle: the older skid entry has priority over new input.
            if (skid_vld_p1) begin
                main_req_p1 <= skid_req_p1;
                main_vld_p1 <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else begin
                main_vld_p1 <= in_fire;
                if (in_fire) begin
                    main_req_p1 <= dec_req_p0;
                end
            end
        end else if (in_fire) begin
            skid_req_p1 <= dec_req_p0;
            skid_vld_p1 <= 1'b1;
        end
    end
`else
    assign in_ready = ~main_vld_p1 | ex.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_p1 <= 1'b0;
            main_req_p1 <= '0;
        end else if (flush) begin
            main_vld_p1 <= 1'b0;
        end else if (in_fire) begin
            main_req_p1 <= dec_req_p0;
            main_vld_p1 <= 1'b1;
        end else if (ex.out_ready) begin
            main_vld_p1 <= 1'b0;
        end
    end
`endif

    assign ex.out_valid   = main_vld_p1;
    assign ex.out_src_a   = main_req_p1.src_a;
    assign ex.out_src_b   = main_req_p1.src_b;
    assign ex.out_op      = main_req_p1.op;
    assign ex.out_alt     = main_req_p1.alt;
    assign ex.out_illegal = main_req_p1.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and streaming bench for alu_issue_stage (build with or without ALU_ISSUE_SKID_EN).
module tb_alu_issue_stage;
    import alu_pkg::*;

`ifdef ALU_ISSUE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [31:0] in_pc;

    alu_issue_stage_if #(.XLEN(32)) ex ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .ex          (ex.master)
    );

    always #5 clk = ~clk;

    int       checks   = 0;
    int       failures = 0;
    int       cyc      = 0;
    int       n_out    = 0;
    logic     fired_in;
    logic     fired_out;
    alu_req_t exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference decode, written from the instruction-set rules.
    function automatic alu_req_t ref_dec(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [31:0] imm,
                                         input logic [31:0] pc);
        alu_req_t r;
        r.src_a = rs1; r.src_b = imm; r.op = 3'd0; r.alt = 1'b0; r.illegal = 1'b0;
        if (opc == 7'h33) begin
            r.src_b = rs2; r.op = f3;
            if (f3 == 3'd0 || f3 == 3'd5) r.alt = f7[5];
        end else if (opc == 7'h13) begin
            r.op = f3;
            if (f3 == 3'd5) r.alt = f7[5];
        end else if (opc == 7'h37) begin
            r.src_a = 32'd0;
        end else if (opc == 7'h17) begin
            r.src_a = pc;
        end else begin
            r.illegal = 1'b1;
        end
        return r;
    endfunction

    function automatic alu_req_t cur_out();
        alu_req_t r;
        r = {ex.out_src_a, ex.out_src_b, ex.out_op, ex.out_alt, ex.out_illegal};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc);
        in_valid = v; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
        in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm; in_pc = pc;
    endtask

    task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic alt, input logic ill);
        check({tag, "_valid"}, ex.out_valid, 1'b1);
        check({tag, "_a"}, ex.out_src_a, a);
        check({tag, "_b"}, ex.out_src_b, b);
        check({tag, "_op"}, ex.out_op, op);
        check({tag, "_alt"}, ex.out_alt, alt);
        check({tag, "_ill"}, ex.out_illegal, ill);
    endtask

    // One clock: sample handshakes, update the scoreboard, advance to the next negedge.
    task automatic step();
        #1;
        fired_in  = in_valid && in_ready && !flush && rst_n;
        fired_out = ex.out_valid && ex.out_ready && !flush && rst_n;
        if (flush || !rst_n) begin
            exp_q.delete();
        end else begin
            if (fired_out) begin
                if (exp_q.size() == 0) check("sb_unexpected_out", ex.out_valid, 1'b0);
                else check("sb_out", cur_out(), exp_q.pop_front());
                n_out++;
            end
            if (fired_in)
                exp_q.push_back(ref_dec(in_opcode, in_funct3, in_funct7, in_rs1_data,
                                        in_rs2_data, in_imm, in_pc));
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, n0, first_c, last_c;

        rst_n = 1'b0; flush = 1'b0; ex.out_ready = 1'b1;
        drive(1'b0, 7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", ex.out_valid, 1'b0);
        check("rst_out", cur_out(), 69'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);

        // Directed decode vectors.
        drive(1'b1, 7'h33, 3'd0, 7'h20, 32'd5, 32'd7, 32'h0, 32'h0);
        @(negedge clk); check_out("sub", 32'd5, 32'd7, 3'd0, 1'b1, 1'b0);
        drive(1'b1, 7'h13, 3'd0, 7'h20, 32'd10, 32'd99, 32'h400, 32'h0);
        @(negedge clk); check_out("addi", 32'd10, 32'h400, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 7'h33, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'h9, 32'h0);
        @(negedge clk); check_out("sra", 32'h80000000, 32'd4, 3'd5, 1'b1, 1'b0);
        drive(1'b1, 7'h33, 3'd4, 7'h20, 32'hF0F0, 32'h0FF0, 32'h9, 32'h0);
        @(negedge clk); check_out("xor", 32'hF0F0, 32'h0FF0, 3'd4, 1'b0, 1'b0);
        drive(1'b1, 7'h37, 3'd3, 7'h20, 32'hDEAD, 32'h1, 32'h12345000, 32'h44);
        @(negedge clk); check_out("lui", 32'h0, 32'h12345000, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 7'h17, 3'd5, 7'h20, 32'hDEAD, 32'h1, 32'h2000, 32'h100);
        @(negedge clk); check_out("auipc", 32'h100, 32'h2000, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 7'h63, 3'd1, 7'h00, 32'h55, 32'h66, 32'h8, 32'h200);
        @(negedge clk); check_out("illegal", 32'h55, 32'h8, 3'd0, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_valid", ex.out_valid, 1'b0);

        // Backpressure: four SRAI entries, EX stalled for three cycles.
        ex.out_ready = 1'b0; idx = 0; n0 = n_out;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 7'h13, 3'd5, 7'h20, 32'h80000000 | idx, 32'h0, idx + 1, 32'h0);
            step();
            if (fired_in) idx++;
        end
        drive(1'b1, 7'h13, 3'd5, 7'h20, 32'h80000000 | idx, 32'h0, idx + 1, 32'h0);
        #1;
        check("bp_accepted", idx, DEPTH);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_hold_valid", ex.out_valid, 1'b1);
        check("bp_hold_a", ex.out_src_a, 32'h80000000);
        check("bp_hold_b", ex.out_src_b, 32'd1);
        ex.out_ready = 1'b1; first_c = -1; last_c = -1;
        for (int c = 0; c < 12 && (n_out - n0) < 4; c++) begin
            if (idx < 4) drive(1'b1, 7'h13, 3'd5, 7'h20, 32'h80000000 | idx, 32'h0, idx + 1, 32'h0);
            else in_valid = 1'b0;
            step();
            if (fired_in) idx++;
            if (fired_out) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
        end
        in_valid = 1'b0;
        check("bp_out_count", n_out - n0, 4);
        check("bp_out_span", last_c - first_c, 3);
        check("bp_q_empty", exp_q.size(), 0);

        // Flush with the stage full and a new beat offered.
        ex.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 7'h33, 3'd0, 7'h00, 32'h1000 + c, 32'h1, 32'h0, 32'h0);
            step();
        end
        drive(1'b1, 7'h33, 3'd0, 7'h00, 32'hBAD0, 32'h1, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        check("fl_full_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_valid", ex.out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        ex.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("fl_no_ghost", ex.out_valid, 1'b0);
        end

        // Reset while entries are held.
        ex.out_ready = 1'b0;
        drive(1'b1, 7'h33, 3'd7, 7'h00, 32'h77, 32'h88, 32'h0, 32'h0);
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("mrst_valid", ex.out_valid, 1'b0);
        check("mrst_a", ex.out_src_a, 32'h0);
        check("mrst_in_ready", in_ready, 1'b1);
        ex.out_ready = 1'b1;
        step();
        check("mrst_no_ghost", ex.out_valid, 1'b0);

        // Streaming: 100 random OP / OP-IMM entries at full rate.
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13, 3'($urandom_range(0, 7)),
                  7'($urandom_range(0, 127)), $urandom, $urandom, $urandom, $urandom);
            step();
            check("st_in_fire", fired_in, 1'b1);
            if (i > 0) check("st_out_fire", fired_out, 1'b1);
        end
        in_valid = 1'b0;
        step();
        check("st_last_out", fired_out, 1'b1);
        check("st_out_count", n_out - n0, 100);
        check("st_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
